// File: rtl/cpu_debug_pkg.sv
// Shared constants for the CPU clock/debug controller: mode encodings and
// the width of the CPU tick counter.
package cpu_debug_pkg;

   // Mode input encodings; 2'b11 is reserved and behaves like halt.
   localparam logic [1:0] MODE_HALT = 2'b00;
   localparam logic [1:0] MODE_RUN  = 2'b01;
   localparam logic [1:0] MODE_STEP = 2'b10;

   // Width of the free-running CPU tick counter (wraps to zero).
   localparam int TICK_COUNT_WIDTH = 16;

endpackage : cpu_debug_pkg

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a debounce counter.
// The accepted level changes only after DEBOUNCE_CYCLES consecutive
// synchronised samples that disagree with it; a 0->1 change of the accepted
// level produces a single-cycle press pulse. Releases produce no pulse.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 4096
)(
   input  logic clock_input,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int                CNT_W     = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1;
   logic             r_sync2;
   logic             r_level;
   logic             r_press;
   logic [CNT_W-1:0] r_count;

   // Two-stage synchroniser for the asynchronous button input.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= raw;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive samples that differ from the accepted level; a sample
   // matching the level restarts the run, the last one of a full run flips it.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
         r_level <= 1'b0;
         r_press <= 1'b0;
      end else if (r_sync2 == r_level) begin
         r_count <= '0;
         r_press <= 1'b0;
      end else if (r_count == CNT_LAST) begin
         r_count <= '0;
         r_level <= r_sync2;
         r_press <= r_sync2;
      end else begin
         r_count <= r_count + 1'b1;
         r_press <= 1'b0;
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule : button_debounce

// File: rtl/cpu_clock_ctrl.sv
// CPU clock-enable and debug probe controller. A free-running divider
// provides a selectable tap; rising edges of that tap become one-clock
// cpu_tick pulses in run mode, or are gated by debounced step presses in
// step mode. Each tick latches the selected probe channel and counts.
//
// cpu_tick handshake: cpu_tick is a registered, single-cycle enable; the CPU
// advances exactly once for each clock in which cpu_tick is high, with no
// back-pressure. probe_out/tick_count reflect that tick one clock later.
module cpu_clock_ctrl
   import cpu_debug_pkg::*;
#(
   parameter int DIV_WIDTH       = 25,
   parameter int DEBOUNCE_CYCLES = 4096,
   parameter int PROBE_CHANNELS  = 4,
   parameter int PROBE_WIDTH     = 16
)(
   input  logic                                     clock_input,
   input  logic                                     reset,
   input  logic [1:0]                               mode,
   input  logic [$clog2(DIV_WIDTH)-1:0]             div_sel,
   input  logic                                     step_button,
   input  logic                                     probe_button,
   input  logic [PROBE_CHANNELS*PROBE_WIDTH-1:0]    probe_in,
   output logic                                     cpu_tick,
   output logic                                     slow_clock,
   output logic [PROBE_WIDTH-1:0]                   probe_out,
   output logic [$clog2(PROBE_CHANNELS)-1:0]        probe_channel,
   output logic [TICK_COUNT_WIDTH-1:0]              tick_count
);

   localparam int               SEL_W   = $clog2(DIV_WIDTH);
   localparam int               CH_W    = $clog2(PROBE_CHANNELS);
   localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(DIV_WIDTH - 1);

   logic [DIV_WIDTH-1:0]        r_divider;
   logic                        r_tap_prev;
   logic [SEL_W-1:0]            r_sel_prev;
   logic                        r_step_pending;
   logic                        r_cpu_tick;
   logic [PROBE_WIDTH-1:0]      r_probe_out;
   logic [CH_W-1:0]             r_channel;
   logic [TICK_COUNT_WIDTH-1:0] r_tick_count;

   logic [SEL_W-1:0]            w_sel_eff;
   logic                        w_tap;
   logic                        w_sel_changed;
   logic                        w_edge;
   logic                        w_tick_next;
   logic                        w_pending_next;
   logic                        w_step_press;
   logic                        w_probe_press;
   logic                        w_step_level_unused;
   logic                        w_probe_level_unused;
   logic [CH_W-1:0]             w_channel_next;
   logic [CH_W-1:0]             w_channel_load;
   logic [PROBE_WIDTH-1:0]      w_channel_word [PROBE_CHANNELS];

   // Clamp the tap select so out-of-range values pick the top divider bit.
   assign w_sel_eff     = (div_sel > SEL_MAX) ? SEL_MAX : div_sel;
   assign w_tap         = r_divider[w_sel_eff];
   // A select change reloads the tap history without reporting an edge, so
   // switching taps can never manufacture a spurious tick.
   assign w_sel_changed = (div_sel != r_sel_prev);
   assign w_edge        = w_tap & ~r_tap_prev & ~w_sel_changed;

   // Free-running divider plus one-cycle history of the selected tap.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         r_divider  <= '0;
         r_tap_prev <= 1'b0;
         r_sel_prev <= '0;
      end else begin
         r_divider  <= r_divider + 1'b1;
         r_tap_prev <= w_tap;
         r_sel_prev <= div_sel;
      end
   end

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_step_debounce (
      .clock_input (clock_input),
      .reset       (reset),
      .raw         (step_button),
      .level       (w_step_level_unused),
      .press       (w_step_press)
   );

   button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_probe_debounce (
      .clock_input (clock_input),
      .reset       (reset),
      .raw         (probe_button),
      .level       (w_probe_level_unused),
      .press       (w_probe_press)
   );

   // Tick and step-pending decision for this cycle, using the live mode so a
   // mode change acts on the first clock it is seen.
   always_comb begin
      w_tick_next    = 1'b0;
      w_pending_next = 1'b0;
      case (mode)
         MODE_RUN: begin
            w_tick_next = w_edge;
         end
         MODE_STEP: begin
            if (w_edge && r_step_pending) begin
               // Serve the pending step; a press arriving now is absorbed.
               w_tick_next = 1'b1;
            end else begin
               w_pending_next = r_step_pending | w_step_press;
            end
         end
         default: begin
            // Halt (and reserved 2'b11): no ticks, pending step discarded.
            w_tick_next    = 1'b0;
            w_pending_next = 1'b0;
         end
      endcase
   end

   // Registered tick pulse and step-pending flag.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         r_cpu_tick     <= 1'b0;
         r_step_pending <= 1'b0;
      end else begin
         r_cpu_tick     <= w_tick_next;
         r_step_pending <= w_pending_next;
      end
   end

   // Split the flat probe bus into per-channel words.
   genvar g_ch;
   generate
      for (g_ch = 0; g_ch < PROBE_CHANNELS; g_ch++) begin : g_probe_split
         assign w_channel_word[g_ch] = probe_in[g_ch*PROBE_WIDTH +: PROBE_WIDTH];
      end
   endgenerate

   // Channel count is a power of two, so the natural wrap gives N-1 -> 0.
   assign w_channel_next = r_channel + 1'b1;
   assign w_channel_load = w_probe_press ? w_channel_next : r_channel;

   // Probe latch, channel select and tick counter; a probe press reloads the
   // new channel immediately and wins over a coincident tick's old channel.
   always_ff @(posedge clock_input or negedge reset) begin
      if (!reset) begin
         r_channel    <= '0;
         r_probe_out  <= '0;
         r_tick_count <= '0;
      end else begin
         if (w_probe_press) begin
            r_channel <= w_channel_next;
         end
         if (w_probe_press || r_cpu_tick) begin
            r_probe_out <= w_channel_word[w_channel_load];
         end
         if (r_cpu_tick) begin
            r_tick_count <= r_tick_count + 1'b1;
         end
      end
   end

   assign cpu_tick      = r_cpu_tick;
   assign slow_clock    = w_tap;
   assign probe_out     = r_probe_out;
   assign probe_channel = r_channel;
   assign tick_count    = r_tick_count;

endmodule : cpu_clock_ctrl
